// File: rtl/abs_sq_beam_scan_if.sv
// Handshake bundle for abs_sq_beam_scan: sample stream, steering
// writes, power output stream and framing error; slave = scanner side.
interface abs_sq_beam_scan_if #(
  parameter int WORD_LENGTH = 12,
  parameter int N_CH        = 4,
  parameter int N_ANG       = 8,
  parameter int OUT_WIDTH   = 32
);
  localparam int AW    = $clog2(N_ANG * N_CH);
  localparam int ANG_W = (N_ANG > 1) ? $clog2(N_ANG) : 1;

  logic                          s_valid;
  logic                          s_ready;
  logic signed [WORD_LENGTH-1:0] s_i;
  logic signed [WORD_LENGTH-1:0] s_q;
  logic                          s_last;

  logic                          coef_we;
  logic                          coef_ready;
  logic [AW-1:0]                 coef_addr;
  logic signed [WORD_LENGTH-1:0] coef_i;
  logic signed [WORD_LENGTH-1:0] coef_q;

  logic                          m_valid;
  logic                          m_ready;
  logic [OUT_WIDTH-1:0]          m_power;
  logic [ANG_W-1:0]              m_angle;
  logic                          m_last;

  logic                          err;

  modport slave (
    input  s_valid, s_i, s_q, s_last,
    input  coef_we, coef_addr, coef_i, coef_q,
    input  m_ready,
    output s_ready, coef_ready,
    output m_valid, m_power, m_angle, m_last,
    output err
  );

  modport master (
    output s_valid, s_i, s_q, s_last,
    output coef_we, coef_addr, coef_i, coef_q,
    output m_ready,
    input  s_ready, coef_ready,
    input  m_valid, m_power, m_angle, m_last,
    input  err
  );
endinterface

// File: rtl/abs_sq_beam_scan.sv
// Beam-power scanner: buffers one N_CH snapshot, then for each of N_ANG
// stored steering vectors emits |sum x_k*s_k|^2 using one complex MAC
// per cycle. Ports: clk, rst_n (async, active low), bus (slave modport:
// s_* samples, coef_* steering RAM writes, m_* power stream, err).
// Define ABS_SQ_BEAM_SAT_EN to saturate m_power instead of keeping MSBs.
module abs_sq_beam_scan #(
  parameter int WORD_LENGTH = 12,
  parameter int N_CH        = 4,
  parameter int N_ANG       = 8,
  parameter int OUT_WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  abs_sq_beam_scan_if.slave bus
);
  localparam int WL    = WORD_LENGTH;
  localparam int ACC_W = 2 * WL + 1 + $clog2(N_CH);
  localparam int POW_W = 2 * ACC_W + 1;
  localparam int DEPTH = N_ANG * N_CH;
  localparam int AW    = $clog2(DEPTH);
  localparam int CH_W  = $clog2(N_CH);
  localparam int ANG_W = (N_ANG > 1) ? $clog2(N_ANG) : 1;
  localparam int EXT_W = ACC_W - 2 * WL;

  localparam logic [CH_W-1:0]  K_LAST = CH_W'(N_CH - 1);
  localparam logic [ANG_W-1:0] A_LAST = ANG_W'(N_ANG - 1);
  localparam logic [AW-1:0]    NCH_A  = AW'(N_CH);

  typedef enum logic [1:0] {
    S_LOAD,
    S_MAC,
    S_SQ,
    S_OUT
  } state_t;

  state_t r_state;

  logic [CH_W-1:0]  r_ch;
  logic [CH_W-1:0]  r_k;
  logic [ANG_W-1:0] r_angle;

  logic signed [ACC_W-1:0] r_acc_i;
  logic signed [ACC_W-1:0] r_acc_q;

  logic signed [WL-1:0] r_buf_i [N_CH];
  logic signed [WL-1:0] r_buf_q [N_CH];

  logic signed [WL-1:0] r_ram_i [DEPTH];
  logic signed [WL-1:0] r_ram_q [DEPTH];

  logic                 r_m_valid;
  logic [OUT_WIDTH-1:0] r_m_power;
  logic [ANG_W-1:0]     r_m_angle;
  logic                 r_m_last;
  logic                 r_err;

  logic                    w_load;
  logic                    w_last_ch;
  logic [AW-1:0]           w_raddr;
  logic signed [WL-1:0]    w_x_i;
  logic signed [WL-1:0]    w_x_q;
  logic signed [WL-1:0]    w_c_i;
  logic signed [WL-1:0]    w_c_q;
  logic signed [2*WL-1:0]  w_m_ii;
  logic signed [2*WL-1:0]  w_m_qq;
  logic signed [2*WL-1:0]  w_m_iq;
  logic signed [2*WL-1:0]  w_m_qi;
  logic signed [ACC_W-1:0] w_p_ii;
  logic signed [ACC_W-1:0] w_p_qq;
  logic signed [ACC_W-1:0] w_p_iq;
  logic signed [ACC_W-1:0] w_p_qi;
  logic signed [2*ACC_W-1:0] w_sq_i;
  logic signed [2*ACC_W-1:0] w_sq_q;
  logic [POW_W-1:0]        w_pow;
  logic [OUT_WIDTH-1:0]    w_out;

  assign w_load    = (r_state == S_LOAD);
  assign w_last_ch = (r_ch == K_LAST);

  assign bus.s_ready    = w_load;
  assign bus.coef_ready = w_load;
  assign bus.m_valid    = r_m_valid;
  assign bus.m_power    = r_m_power;
  assign bus.m_angle    = r_m_angle;
  assign bus.m_last     = r_m_last;
  assign bus.err        = r_err;

  // Steering RAM keeps its contents across rst_n.
  always_ff @(posedge clk) begin
    if (bus.coef_we && w_load &&
        32'(bus.coef_addr) < DEPTH) begin
      r_ram_i[bus.coef_addr] <= bus.coef_i;
      r_ram_q[bus.coef_addr] <= bus.coef_q;
    end
  end

  assign w_raddr = AW'(r_angle) * NCH_A + AW'(r_k);
  assign w_c_i   = r_ram_i[w_raddr];
  assign w_c_q   = r_ram_q[w_raddr];
  assign w_x_i   = r_buf_i[r_k];
  assign w_x_q   = r_buf_q[r_k];

  assign w_m_ii = w_x_i * w_c_i;
  assign w_m_qq = w_x_q * w_c_q;
  assign w_m_iq = w_x_i * w_c_q;
  assign w_m_qi = w_x_q * w_c_i;

  assign w_p_ii = {{EXT_W{w_m_ii[2*WL-1]}}, w_m_ii};
  assign w_p_qq = {{EXT_W{w_m_qq[2*WL-1]}}, w_m_qq};
  assign w_p_iq = {{EXT_W{w_m_iq[2*WL-1]}}, w_m_iq};
  assign w_p_qi = {{EXT_W{w_m_qi[2*WL-1]}}, w_m_qi};

  // Squares are non-negative, so a zero MSB makes them unsigned.
  assign w_sq_i = r_acc_i * r_acc_i;
  assign w_sq_q = r_acc_q * r_acc_q;
  assign w_pow  = {1'b0, w_sq_i} + {1'b0, w_sq_q};

  generate
    if (OUT_WIDTH >= POW_W) begin : g_zext
      assign w_out = OUT_WIDTH'(w_pow);
    end else begin : g_fit
`ifdef ABS_SQ_BEAM_SAT_EN
      assign w_out = ((w_pow >> OUT_WIDTH) != '0) ?
                     '1 : OUT_WIDTH'(w_pow);
`else
      assign w_out = OUT_WIDTH'(w_pow >> (POW_W - OUT_WIDTH));
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_LOAD;
      r_ch      <= '0;
      r_k       <= '0;
      r_angle   <= '0;
      r_acc_i   <= '0;
      r_acc_q   <= '0;
      r_m_valid <= 1'b0;
      r_m_power <= '0;
      r_m_angle <= '0;
      r_m_last  <= 1'b0;
      r_err     <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_buf_i[i] <= '0;
        r_buf_q[i] <= '0;
      end
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_LOAD: begin
          if (bus.s_valid) begin
            r_buf_i[r_ch] <= bus.s_i;
            r_buf_q[r_ch] <= bus.s_q;
            if (w_last_ch && bus.s_last) begin
              r_state <= S_MAC;
              r_ch    <= '0;
              r_k     <= '0;
              r_angle <= '0;
              r_acc_i <= '0;
              r_acc_q <= '0;
            end else if (w_last_ch || bus.s_last) begin
              // Misframed snapshot: drop it and restart at channel 0.
              r_ch  <= '0;
              r_err <= 1'b1;
            end else begin
              r_ch <= r_ch + 1'b1;
            end
          end
        end
        S_MAC: begin
          r_acc_i <= r_acc_i + w_p_ii - w_p_qq;
          r_acc_q <= r_acc_q + w_p_iq + w_p_qi;
          if (r_k == K_LAST) begin
            r_k     <= '0;
            r_state <= S_SQ;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_SQ: begin
          r_m_power <= w_out;
          r_m_valid <= 1'b1;
          r_m_angle <= r_angle;
          r_m_last  <= (r_angle == A_LAST);
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            if (r_angle == A_LAST) begin
              r_angle <= '0;
              r_ch    <= '0;
              r_state <= S_LOAD;
            end else begin
              r_angle <= r_angle + 1'b1;
              r_acc_i <= '0;
              r_acc_q <= '0;
              r_state <= S_MAC;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_abs_sq_beam_scan.sv
// Directed bench for abs_sq_beam_scan: table of snapshots with
// steering patterns, plus stall, framing and mid-sweep reset sequences.
module tb_abs_sq_beam_scan;
  localparam int WL    = 12;
  localparam int NCH   = 4;
  localparam int NANG  = 8;
  localparam int OW    = 32;
  localparam int POW_W = 55;
  localparam int NROW  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  abs_sq_beam_scan_if #(
    .WORD_LENGTH(WL), .N_CH(NCH),
    .N_ANG(NANG), .OUT_WIDTH(OW)
  ) bus ();

  abs_sq_beam_scan #(
    .WORD_LENGTH(WL), .N_CH(NCH),
    .N_ANG(NANG), .OUT_WIDTH(OW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int                       pat;
    logic [NCH-1:0][WL-1:0]   xi;
    logic [NCH-1:0][WL-1:0]   xq;
    int                       hand_a;
    longint                   hand_pow;
  } vec_t;

  vec_t tv [NROW];

  int checks = 0;
  int errors = 0;
  int cur_pat = 0;
  logic [NCH-1:0][WL-1:0] cur_xi;
  logic [NCH-1:0][WL-1:0] cur_xq;

  function automatic vec_t mk(
    input int p,
    input int i0, input int q0, input int i1, input int q1,
    input int i2, input int q2, input int i3, input int q3,
    input int ha, input longint hp
  );
    vec_t v;
    v.pat = p;
    v.xi[0] = 12'(i0); v.xq[0] = 12'(q0);
    v.xi[1] = 12'(i1); v.xq[1] = 12'(q1);
    v.xi[2] = 12'(i2); v.xq[2] = 12'(q2);
    v.xi[3] = 12'(i3); v.xq[3] = 12'(q3);
    v.hand_a = ha;
    v.hand_pow = hp;
    return v;
  endfunction

  // Steering patterns: 0 ones, 1 quadrature at angle 1,
  // 2 full-scale negative, 3 angle/channel dependent mix.
  function automatic void coef_val(
    input int p, input int a, input int k,
    output int ci, output int cq
  );
    case (p)
      0: begin ci = 1; cq = 0; end
      1: begin
        if (a == 1) begin ci = 0; cq = 1; end
        else begin ci = 1; cq = 0; end
      end
      2: begin ci = -2048; cq = 0; end
      default: begin
        ci = 60 * (a + 1) * (k + 1);
        cq = 100 * (a - k);
      end
    endcase
  endfunction

  function automatic longint model_pow(input int a);
    longint ai = 0;
    longint aq = 0;
    longint xi, xq;
    int ci, cq;
    for (int k = 0; k < NCH; k++) begin
      xi = longint'($signed(cur_xi[k]));
      xq = longint'($signed(cur_xq[k]));
      coef_val(cur_pat, a, k, ci, cq);
      ai += xi * ci - xq * cq;
      aq += xi * cq + xq * ci;
    end
    return ai * ai + aq * aq;
  endfunction

  function automatic longint map_pow(input longint p);
    longint lim;
    lim = (longint'(1) << OW) - 1;
`ifdef ABS_SQ_BEAM_SAT_EN
    return (p > lim) ? lim : p;
`else
    if (lim < 0) return 0;
    return p >>> (POW_W - OW);
`endif
  endfunction

  task automatic chk(
    input string nm, input longint act, input longint exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr_coef(input int addr, input int ci, input int cq);
    @(negedge clk);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 5'(addr);
    bus.coef_i    = 12'(ci);
    bus.coef_q    = 12'(cq);
    @(posedge clk);
    #1 bus.coef_we = 1'b0;
  endtask

  task automatic load_pat(input int p);
    int ci, cq;
    cur_pat = p;
    for (int a = 0; a < NANG; a++)
      for (int k = 0; k < NCH; k++) begin
        coef_val(p, a, k, ci, cq);
        wr_coef(a * NCH + k, ci, cq);
      end
  endtask

  task automatic send(input int xi, input int xq, input bit last);
    int n = 0;
    @(negedge clk);
    while (!bus.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: got 0 expected 1");
    end
    bus.s_valid = 1'b1;
    bus.s_i     = 12'(xi);
    bus.s_q     = 12'(xq);
    bus.s_last  = last;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_snap(input vec_t v);
    cur_xi = v.xi;
    cur_xq = v.xq;
    for (int k = 0; k < NCH; k++)
      send(int'($signed(v.xi[k])), int'($signed(v.xq[k])),
           k == NCH - 1);
  endtask

  task automatic collect(
    input int n_take, input int stall_a,
    input int hand_a, input longint hand_pow
  );
    for (int a = 0; a < n_take; a++) begin
      int n;
      bit stable;
      longint held;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.m_valid && n < 40);
      if (!bus.m_valid) begin
        checks++;
        errors++;
        $display("FAIL m_valid_timeout: got 0 expected 1 at angle %0d", a);
        return;
      end
      chk("latency", n, NCH + 2);
      chk("m_angle", bus.m_angle, a);
      chk("m_power", bus.m_power, map_pow(model_pow(a)));
      chk("m_last", bus.m_last, (a == NANG - 1) ? 1 : 0);
      if (a == hand_a)
        chk("hand_power", bus.m_power, map_pow(hand_pow));
      if (a == stall_a) begin
        stable = 1'b1;
        held = bus.m_power;
        for (int i = 0; i < 10; i++) begin
          if (i == 0) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = 5'(a * NCH + 1);
            bus.coef_i    = 12'h7ff;
            bus.coef_q    = 12'h7ff;
          end
          @(negedge clk);
          bus.coef_we = 1'b0;
          if (!bus.m_valid || bus.m_power != held ||
              bus.m_angle != 3'(a))
            stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
      end
      bus.m_ready = 1'b1;
      @(posedge clk);
      #1 bus.m_ready = 1'b0;
    end
    if (n_take == NANG) begin
      @(negedge clk);
      chk("s_ready_after", bus.s_ready, 1);
      chk("m_valid_after", bus.m_valid, 0);
    end
  endtask

  task automatic quiet(input string nm, input int cyc);
    bit seen = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (bus.m_valid) seen = 1'b1;
    end
    chk(nm, seen, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.s_valid   = 1'b0;
    bus.s_i       = '0;
    bus.s_q       = '0;
    bus.s_last    = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_i    = '0;
    bus.coef_q    = '0;
    bus.m_ready   = 1'b0;

    tv[0] = mk(0, 100, 0, 100, 0, 100, 0, 100, 0, 7, 160000);
    tv[1] = mk(1, 100, 0, 100, 0, 100, 0, 100, 0, 1, 160000);
    tv[2] = mk(2, -2048, 0, -2048, 0, -2048, 0, -2048, 0,
               0, 64'd281474976710656);
    tv[3] = mk(2, 1000, -500, 1000, -500, 1000, -500, 1000, -500,
               5, 64'd83886080000000);
    tv[4] = mk(3, 1000, 0, 0, 1000, -1000, 0, 500, 500,
               0, 64'd146600000000);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_coef_ready", bus.coef_ready, 1);
    chk("rst_m_power", bus.m_power, 0);
    chk("rst_m_angle", bus.m_angle, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < NROW; r++) begin
      load_pat(tv[r].pat);
      send_snap(tv[r]);
      collect(NANG, -1, tv[r].hand_a, tv[r].hand_pow);
    end

    send_snap(tv[4]);
    collect(NANG, 3, -1, 0);

    send(10, 0, 1'b0);
    send(20, 0, 1'b1);
    @(negedge clk);
    chk("err_early_last", bus.err, 1);
    @(negedge clk);
    chk("err_pulse_end", bus.err, 0);
    quiet("framing_no_out", 10);
    for (int k = 0; k < NCH; k++) send(5, 5, 1'b0);
    @(negedge clk);
    chk("err_missing_last", bus.err, 1);
    send_snap(tv[4]);
    collect(NANG, -1, 0, tv[4].hand_pow);

    load_pat(0);
    send_snap(tv[0]);
    collect(4, -1, -1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_s_ready", bus.s_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    quiet("midrst_no_out", 12);
    send_snap(tv[0]);
    collect(NANG, -1, 7, 160000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
